multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
Multi-channel countdown timer, the parametrised successor to the single one-shot timer. Runs CHANNELS independent down-counters from one shared free-running prescaler tick (default 27 clk ≈ 1 µs). Each channel is one-shot or auto-reload periodic, with its own sticky interrupt flag, interrupt enable and readback. Sits on the CPU peripheral bus and drives one combined irq line plus per-channel flags.

Parameters:
CHANNELS, 4, number of timer channels (1..16)
CH_BITS, 2, channel select width, CHANNELS <= 2**CH_BITS
BITS, 32, counter/reload width
PRESCALER_BITS, 5, prescaler counter width
PRESCALER_VALUE, 26, prescaler terminal count; tick every PRESCALER_VALUE+1 clk

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous active-low reset
nwr  in  1  active-low write strobe, one clk per write
channel  in  CH_BITS  channel select for write and read
reg_sel  in  1  0 = load register, 1 = control register
wdata  in  BITS  write data
rdata  out  BITS  combinational readback of selected channel/register
interrupt  out  CHANNELS  per-channel sticky interrupt flags
interrupt_clear  in  CHANNELS  per-channel clear, level, sampled each clk
irq  out  1  OR of (interrupt & enable), registered

Behaviour:
- Reset (async, nreset=0): prescaler=0; all counters, reloads, periodic, enable = 0; done=1; interrupt=0; irq=0.
- Prescaler: free-running 0..PRESCALER_VALUE. tick=1 in the clk where prescaler==PRESCALER_VALUE. Never reset by writes. First decrement therefore comes 1..PRESCALER_VALUE+1 clk after a load.
- Load write (nwr=0, reg_sel=0, channel<CHANNELS): counter<=wdata, reload<=wdata, done<=0, interrupt[ch]<=0. Overrides any tick or set on that channel in the same clk.
- Control write (reg_sel=1): bit0 periodic, bit1 enable, bit2 stop. Counter is unaffected unless stop=1. stop=1 sets counter<=0 and done<=1, and raises no interrupt.
- Writes with channel>=CHANNELS are ignored. Reads of such a channel return 0.
- Countdown: on tick, if counter!=0 then counter<=counter-1.
- Periodic expiry: tick && counter==1 && periodic && reload!=0 → counter<=reload, interrupt<=1 in the same clk. Period is exactly reload ticks with no slip.
- One-shot expiry: counter==0 && !done → interrupt<=1, done<=1 one clk later. This includes a load of 0, which raises the interrupt 1 clk after the write.
- Periodic with reload==0 behaves as one-shot (single interrupt, then stop).
- Flag priority per clk: load write clear > set > interrupt_clear. A set coinciding with interrupt_clear leaves the flag set.
- Flags set regardless of enable (pollable). irq <= |(interrupt & enable), one clk after the flag.
- rdata: reg_sel=0 → live counter. reg_sel=1 → {zeros, interrupt, enable, periodic} in bits [2:0].
- Channels are fully independent. Simultaneous expiries on several channels all set their flags in the same clk.
- Reset mid-count: all state returns to reset values immediately. No interrupt is raised after reset release.

Test Plan:
- Reset → interrupt=0, irq=0, rdata=0 for every channel. Release nreset, idle 200 clk → no flag set.
- Ch0 one-shot, enable=1, load 3 → counter steps 3,2,1,0 on successive ticks. interrupt[0]=1 1 clk after reaching 0, irq 1 clk later. Fires once only. interrupt_clear[0] → 0.
- Ch1 periodic, load 2 → interrupt[1] sets every 54 clk (2 ticks). Counter reloads 2 with no 0 state. Clear between expiries, flag sets again. Stop write → counter=0, no further flags.
- Ch2 load 0 → interrupt[2]=1 exactly 1 clk after the write. Ch3 enable=0, load 1 → interrupt[3] sets but irq stays 0.
- Ch0 and ch1 expire in the same clk while interrupt_clear[0]=1 → both flags 1. Reload ch0 during the count → old expiry suppressed and the flag is cleared.
- Assert nreset while ch1 is periodic mid-count → outputs 0 asynchronously. After release, no interrupt for 500 clk.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel countdown timer: CHANNELS independent one-shot/periodic
// down-counters sharing one free-running prescaler tick, with sticky flags and irq.
package multi_timer_pkg;
  typedef struct packed {
    logic tick;  // shared prescaler tick
    logic ld;    // load write addressed to this channel
    logic cw;    // control write addressed to this channel
    logic clr;   // interrupt_clear level for this channel
  } ch_req_t;
endpackage

module multi_timer_ch #(
  parameter int BITS = 32
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  multi_timer_pkg::ch_req_t req,
  input  logic [BITS-1:0]         wdata,
  output logic [BITS-1:0]         count,
  output logic                    intr,
  output logic                    enable,
  output logic                    periodic
);
  logic [BITS-1:0] reload;
  logic            done;
  logic            stop;
  logic            per_exp;
  logic            os_exp;
  logic            set;

  // Periodic expiry reloads on the tick that would reach 0, so the period is
  // exactly reload ticks and the counter never shows 0 while running.
  always_comb begin
    stop    = req.cw & wdata[2];
    per_exp = req.tick && (count == BITS'(1)) && periodic && (reload != '0);
    os_exp  = (count == '0) && !done;
    set     = (per_exp | os_exp) & ~stop;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count    <= '0;
      reload   <= '0;
      periodic <= 1'b0;
      enable   <= 1'b0;
      done     <= 1'b1;
      intr     <= 1'b0;
    end else begin
      if (req.cw) begin
        periodic <= wdata[0];
        enable   <= wdata[1];
      end
      if (req.ld) begin
        count  <= wdata;
        reload <= wdata;
        done   <= 1'b0;
        intr   <= 1'b0;
      end else begin
        if (stop) begin
          count <= '0;
          done  <= 1'b1;
        end else if (per_exp) begin
          count <= reload;
        end else if (req.tick && (count != '0)) begin
          count <= count - BITS'(1);
        end
        if (os_exp) done <= 1'b1;
        // a set wins over a coincident clear so no expiry is lost
        if (set)          intr <= 1'b1;
        else if (req.clr) intr <= 1'b0;
      end
    end
  end
endmodule

module multi_timer #(
  parameter int CHANNELS        = 4,
  parameter int CH_BITS         = 2,
  parameter int BITS            = 32,
  parameter int PRESCALER_BITS  = 5,
  parameter int PRESCALER_VALUE = 26
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                nwr,
  input  logic [CH_BITS-1:0]  channel,
  input  logic                reg_sel,
  input  logic [BITS-1:0]     wdata,
  output logic [BITS-1:0]     rdata,
  output logic [CHANNELS-1:0] interrupt,
  input  logic [CHANNELS-1:0] interrupt_clear,
  output logic                irq
);
  logic [PRESCALER_BITS-1:0]       prescaler;
  logic                            tick;
  logic [CHANNELS-1:0][BITS-1:0]   count;
  logic [CHANNELS-1:0]             enable;
  logic [CHANNELS-1:0]             periodic;

  // Prescaler is never disturbed by writes; load-to-first-tick latency varies.
  assign tick = (prescaler == PRESCALER_BITS'(PRESCALER_VALUE));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)   prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + PRESCALER_BITS'(1);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    multi_timer_pkg::ch_req_t req;
    logic sel;
    assign sel      = !nwr && (channel == CH_BITS'(g));
    assign req.tick = tick;
    assign req.ld   = sel && !reg_sel;
    assign req.cw   = sel && reg_sel;
    assign req.clr  = interrupt_clear[g];

    multi_timer_ch #(.BITS(BITS)) u_ch (
      .clk      (clk),
      .nreset   (nreset),
      .req      (req),
      .wdata    (wdata),
      .count    (count[g]),
      .intr     (interrupt[g]),
      .enable   (enable[g]),
      .periodic (periodic[g])
    );
  end

  // Unpopulated channel numbers match no lane and read back as 0.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (channel == CH_BITS'(i))
        rdata = reg_sel ? {{(BITS-3){1'b0}}, interrupt[i], enable[i], periodic[i]}
                        : count[i];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) irq <= 1'b0;
    else         irq <= |(interrupt & enable);
  end
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: cycle-exact expectations derived from the
// prescaler phase (tick on every 27th clk after reset release).
module tb_multi_timer;
  logic        clk = 1'b0;
  logic        nreset;
  logic        nwr;
  logic [1:0]  channel;
  logic        reg_sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  interrupt;
  logic [3:0]  interrupt_clear;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc;
  int t;
  logic [31:0] v;

  multi_timer dut (
    .clk             (clk),
    .nreset          (nreset),
    .nwr             (nwr),
    .channel         (channel),
    .reg_sel         (reg_sel),
    .wdata           (wdata),
    .rdata           (rdata),
    .interrupt       (interrupt),
    .interrupt_clear (interrupt_clear),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  // posedges since reset release; tick edges are those where cyc becomes a multiple of 27
  always @(posedge clk or negedge nreset)
    if (!nreset) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic wait_until(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("cycle_sync", cyc, c);
  endtask

  task automatic align27();
    int guard = 0;
    while ((cyc % 27) != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("align", cyc % 27, 0);
  endtask

  task automatic wr(input logic [1:0] ch, input logic sel, input logic [31:0] d);
    channel = ch; reg_sel = sel; wdata = d; nwr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nwr = 1'b1;
  endtask

  task automatic rd(input logic [1:0] ch, input logic sel, output logic [31:0] val);
    channel = ch; reg_sel = sel;
    #1;
    val = rdata;
  endtask

  task automatic pulse_clr(input logic [3:0] m);
    interrupt_clear = m;
    @(posedge clk);
    @(negedge clk);
    interrupt_clear = '0;
  endtask

  initial begin
    nreset = 1'b0; nwr = 1'b1; channel = '0; reg_sel = 1'b0;
    wdata = '0; interrupt_clear = '0;
    #3;
    chk("rst_interrupt", {28'd0, interrupt}, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), 1'b0, v); chk("rst_count", v, 0);
      rd(2'(c), 1'b1, v); chk("rst_ctrl", v, 0);
    end
    @(negedge clk);
    nreset = 1'b1;
    wait_until(200);
    chk("idle_interrupt", {28'd0, interrupt}, 0);
    chk("idle_irq", {31'd0, irq}, 0);

    // ch0 one-shot, enabled, load 3
    wr(2'd0, 1'b1, 32'h2);
    align27(); t = cyc;
    wr(2'd0, 1'b0, 32'd3);
    rd(2'd0, 1'b0, v); chk("os_cnt3", v, 3);
    wait_until(t + 27); rd(2'd0, 1'b0, v); chk("os_cnt2", v, 2);
    wait_until(t + 54); rd(2'd0, 1'b0, v); chk("os_cnt1", v, 1);
    wait_until(t + 81); rd(2'd0, 1'b0, v); chk("os_cnt0", v, 0);
    chk("os_flag_pre", {31'd0, interrupt[0]}, 0);
    wait_until(t + 82);
    chk("os_flag", {31'd0, interrupt[0]}, 1);
    chk("os_irq_pre", {31'd0, irq}, 0);
    wait_until(t + 83);
    chk("os_irq", {31'd0, irq}, 1);
    wait_until(t + 200);
    chk("os_sticky", {31'd0, interrupt[0]}, 1);
    rd(2'd0, 1'b1, v); chk("os_ctrl_rd", v, 32'h6);
    pulse_clr(4'b0001);
    chk("os_clear", {31'd0, interrupt[0]}, 0);
    @(negedge clk);
    chk("os_irq_drop", {31'd0, irq}, 0);
    repeat (100) @(negedge clk);
    chk("os_once", {28'd0, interrupt}, 0);

    // ch1 periodic, enabled, load 2
    wr(2'd1, 1'b1, 32'h3);
    align27(); t = cyc;
    wr(2'd1, 1'b0, 32'd2);
    wait_until(t + 27); rd(2'd1, 1'b0, v); chk("per_cnt1", v, 1);
    wait_until(t + 53); chk("per_flag_pre", {31'd0, interrupt[1]}, 0);
    wait_until(t + 54); chk("per_flag1", {31'd0, interrupt[1]}, 1);
    rd(2'd1, 1'b0, v); chk("per_reload", v, 2);
    wait_until(t + 55); chk("per_irq", {31'd0, irq}, 1);
    wait_until(t + 60); pulse_clr(4'b0010);
    chk("per_clear", {31'd0, interrupt[1]}, 0);
    wait_until(t + 107); chk("per_flag2_pre", {31'd0, interrupt[1]}, 0);
    wait_until(t + 108); chk("per_flag2", {31'd0, interrupt[1]}, 1);
    wait_until(t + 110);
    wr(2'd1, 1'b1, 32'h7);
    rd(2'd1, 1'b0, v); chk("stop_cnt", v, 0);
    rd(2'd1, 1'b1, v); chk("stop_ctrl", v, 32'h7);
    pulse_clr(4'b0010);
    wait_until(t + 260);
    chk("stop_noflag", {28'd0, interrupt}, 0);
    rd(2'd1, 1'b0, v); chk("stop_cnt_hold", v, 0);

    // ch2 load 0 fires one clk after the write
    wr(2'd2, 1'b0, 32'd0);
    chk("ld0_pre", {31'd0, interrupt[2]}, 0);
    @(negedge clk);
    chk("ld0_flag", {31'd0, interrupt[2]}, 1);

    // ch3 disabled: flag sets, irq stays low
    wr(2'd3, 1'b1, 32'h0);
    align27(); t = cyc;
    wr(2'd3, 1'b0, 32'd1);
    wait_until(t + 27); chk("dis_flag_pre", {31'd0, interrupt[3]}, 0);
    wait_until(t + 30);
    chk("dis_flags", {28'd0, interrupt}, 32'hC);
    chk("dis_irq", {31'd0, irq}, 0);
    pulse_clr(4'b1100);
    chk("dis_clear", {28'd0, interrupt}, 0);

    // ch0 and ch1 both periodic, expiring in the same clk with clear[0] held
    wr(2'd0, 1'b1, 32'h3);
    align27(); t = cyc;
    wr(2'd0, 1'b0, 32'd2);
    wr(2'd1, 1'b0, 32'd2);
    wait_until(t + 53);
    chk("sim_pre", {28'd0, interrupt}, 0);
    interrupt_clear = 4'b0001;
    @(negedge clk);
    interrupt_clear = '0;
    chk("sim_both", {28'd0, interrupt}, 32'h3);
    wait_until(t + 60);
    wr(2'd0, 1'b0, 32'd5);
    chk("reld_clear", {31'd0, interrupt[0]}, 0);
    rd(2'd0, 1'b0, v); chk("reld_cnt5", v, 5);
    pulse_clr(4'b0010);
    wait_until(t + 108);
    chk("reld_suppr", {28'd0, interrupt}, 32'h2);
    rd(2'd0, 1'b0, v); chk("reld_cnt3", v, 3);

    // async reset while ch1 is running periodic
    #2 nreset = 1'b0;
    #1;
    chk("arst_interrupt", {28'd0, interrupt}, 0);
    chk("arst_irq", {31'd0, irq}, 0);
    rd(2'd1, 1'b0, v); chk("arst_cnt", v, 0);
    rd(2'd1, 1'b1, v); chk("arst_ctrl", v, 0);
    @(negedge clk);
    nreset = 1'b1;
    wait_until(500);
    chk("post_interrupt", {28'd0, interrupt}, 0);
    chk("post_irq", {31'd0, irq}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
